expr_eval: RTL and testbench

EXPR_EVAL -- requirements
Module: expr_eval

---
 rtl/expr_eval_if.sv | 15 +
 rtl/expr_eval.sv | 106 ++++++++++
 tb/tb_expr_eval.sv | 133 +++++++++++++
 3 files changed

// File: rtl/expr_eval_if.sv
// Character stream into the expression evaluator and its status outputs back.
// The source drives in/in_valid; the evaluator drives result/ok/err/ovf.
interface expr_eval_if;
  logic [7:0]  in;
  logic        in_valid;
  logic [15:0] result;
  logic        ok;
  logic        err;
  logic        ovf;

  modport master (output in, output in_valid,
                  input result, input ok, input err, input ovf);
  modport slave  (input in, input in_valid,
                  output result, output ok, output err, output ovf);
endinterface

// File: rtl/expr_eval.sv
// Streaming evaluator for D (op D)* with single-digit operands, '*' over '+'.
// Optional sticky overflow flag is compiled in with EXPR_EVAL_OVF_EN.
module expr_eval (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, NUM, OP, ERR} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_sum, r_prod, r_result;
  logic [3:0]  w_d;
  logic        w_is_digit, w_is_plus, w_is_star;
  logic        w_load_digit, w_load_plus;
  logic        w_ok, w_err;
  logic [15:0] w_mul, w_acc, w_add;

  assign w_d        = bus.in[3:0];
  assign w_is_digit = (bus.in[7:4] == 4'h3) && (bus.in[3:0] <= 4'h9);
  assign w_is_plus  = (bus.in == 8'h2B);
  assign w_is_star  = (bus.in == 8'h2A);

`ifdef EXPR_EVAL_OVF_EN
  logic [19:0] w_mul_full;
  logic [20:0] w_acc_full;
  logic [16:0] w_add_full;
  logic        r_ovf;

  assign w_mul_full = 20'(r_prod) * 20'(w_d);
  assign w_acc_full = 21'(r_sum) + 21'(w_mul_full);
  assign w_add_full = 17'(r_sum) + 17'(r_prod);
  assign w_mul      = w_mul_full[15:0];
  assign w_acc      = w_acc_full[15:0];
  assign w_add      = w_add_full[15:0];

  // Sticky: only clr clears it, and it never feeds back into ok/err.
  always_ff @(posedge clk) begin
    if (clr)
      r_ovf <= 1'b0;
    else if ((w_load_digit && ((w_mul_full > 20'd65535) || (w_acc_full > 21'd65535))) ||
             (w_load_plus && w_add_full[16]))
      r_ovf <= 1'b1;
  end
  assign bus.ovf = r_ovf;
`else
  assign w_mul   = r_prod * {12'd0, w_d};
  assign w_acc   = r_sum + w_mul;
  assign w_add   = r_sum + r_prod;
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load_digit = 1'b0;
    w_load_plus  = 1'b0;
    w_ok         = (r_state == NUM);
    w_err        = (r_state == ERR);
    if (bus.in_valid) begin
      case (r_state)
        IDLE, OP: begin
          if (w_is_digit) begin
            w_state_next = NUM;
            w_load_digit = 1'b1;
          end else begin
            w_state_next = ERR;
          end
        end
        NUM: begin
          if (w_is_plus || w_is_star) begin
            w_state_next = OP;
            w_load_plus  = w_is_plus;
          end else begin
            w_state_next = ERR;
          end
        end
        default: w_state_next = ERR;
      endcase
    end
  end

  // sum holds closed '+' terms; prod is the open '*' term, so a STAR needs no update.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sum    <= 16'd0;
      r_prod   <= 16'd1;
      r_result <= 16'd0;
    end else if (w_load_digit) begin
      r_prod   <= w_mul;
      r_result <= w_acc;
    end else if (w_load_plus) begin
      r_sum    <= w_add;
      r_prod   <= 16'd1;
    end
  end

  assign bus.result = r_result;
  assign bus.ok     = w_ok;
  assign bus.err    = w_err;
endmodule

// File: tb/tb_expr_eval.sv
// Directed test of expr_eval: precedence, errors, clr priority, idle hold, overflow.
module tb_expr_eval;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   total = 0;
  int   bad   = 0;

  expr_eval_if bus_if ();

  expr_eval dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

`ifdef EXPR_EVAL_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] res,
                           input logic ok_e, input logic err_e);
    check({tag, ".result"}, bus_if.result, res);
    check({tag, ".ok"}, 16'(bus_if.ok), 16'(ok_e));
    check({tag, ".err"}, 16'(bus_if.err), 16'(err_e));
    $display("step %s: result=%0d ok=%0b err=%0b ovf=%0b", tag,
             bus_if.result, bus_if.ok, bus_if.err, bus_if.ovf);
  endtask

  task automatic send(input logic [7:0] c);
    bus_if.in       = c;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    bus_if.in       = 8'h00;
    bus_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    pulse_clr();
    check_all("reset", 16'd0, 1'b0, 1'b0);
    check("reset.ovf", 16'(bus_if.ovf), 16'd0);

    // "1+2*3" -> 7
    send("1"); check_all("a1", 16'd1, 1'b1, 1'b0);
    send("+"); check_all("a+", 16'd1, 1'b0, 1'b0);
    send("2"); check_all("a2", 16'd3, 1'b1, 1'b0);
    send("*"); check_all("a*", 16'd3, 1'b0, 1'b0);
    send("3"); check_all("a3", 16'd7, 1'b1, 1'b0);

    // "2*3+4" -> 10, trailing "+" keeps result
    pulse_clr();
    send("2"); send("*"); send("3");
    check_all("b6", 16'd6, 1'b1, 1'b0);
    send("+"); send("4");
    check_all("b10", 16'd10, 1'b1, 1'b0);
    send("+");
    check_all("b_trail", 16'd10, 1'b0, 1'b0);

    // "12" -> error, stays sticky through "+5"
    pulse_clr();
    send("1"); check_all("c1", 16'd1, 1'b1, 1'b0);
    send("2"); check_all("c12", 16'd1, 1'b0, 1'b1);
    send("+"); send("5");
    check_all("c_sticky", 16'd1, 1'b0, 1'b1);

    // illegal first character
    pulse_clr();
    send("a"); check_all("d_illegal", 16'd0, 1'b0, 1'b1);

    // "3+", clr mid-expression, then "4"
    pulse_clr();
    send("3"); send("+");
    check_all("e3+", 16'd3, 1'b0, 1'b0);
    pulse_clr();
    send("4"); check_all("e4", 16'd4, 1'b1, 1'b0);

    // clr wins over a simultaneous valid digit
    bus_if.in = "5"; bus_if.in_valid = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0; clr = 1'b0;
    check_all("f_clr_pri", 16'd0, 1'b0, 1'b0);

    // "9*9*9*9*9*9" -> 531441 mod 65536 = 7153
    pulse_clr();
    send("9"); send("*"); send("9"); send("*"); send("9");
    check_all("g729", 16'd729, 1'b1, 1'b0);
    check("g729.ovf", 16'(bus_if.ovf), 16'd0);
    send("*"); send("9"); send("*"); send("9");
    check_all("g59049", 16'd59049, 1'b1, 1'b0);
    check("g59049.ovf", 16'(bus_if.ovf), 16'd0);
    send("*"); send("9");
    check_all("g7153", 16'd7153, 1'b1, 1'b0);
    check("g7153.ovf", 16'(bus_if.ovf), 16'(OVF_EXP));
    pulse_clr();
    check("g_clr.ovf", 16'(bus_if.ovf), 16'd0);

    // "7" then idle cycles with illegal codes on in
    send("7"); check_all("h7", 16'd7, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus_if.in = (i % 2 == 0) ? 8'h41 : 8'h7F;
      @(posedge clk);
      #1;
      check_all($sformatf("h_idle%0d", i), 16'd7, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
